// File: rtl/sprite_mover.sv
// Per-frame sprite motion controller with edge bounce and tear-free buffered register writes.
// Latency: position/bounce update one clk_pix after the frame pulse; spr_start is combinational.
// Backpressure: none; writes are always accepted and held pending until the next frame pulse.
module sprite_mover #(
    parameter int CORDW  = 16,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int INIT_X = 16,
    parameter int INIT_Y = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    run,
    input  logic                    wr_en,
    input  logic [1:0]              wr_sel,
    input  logic [7:0]              wr_data,
    output logic signed [CORDW-1:0] sprx,
    output logic signed [CORDW-1:0] spry,
    output logic                    spr_start,
    output logic                    bounce,
    output logic [7:0]              bounce_cnt,
    output logic                    moving
);
    // Limits are held one bit wider than positions so x+spx never wraps.
    localparam logic [CORDW:0] X_MAX = (CORDW+1)'(H_RES - SPR_W);
    localparam logic [CORDW:0] Y_MAX = (CORDW+1)'(V_RES - SPR_H);

    typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;
    state_t state, state_nx;

    logic [CORDW-1:0] x_q, y_q, x_p, y_p;
    logic             dx, dy;
    logic [3:0]       spx, spy, spx_p, spy_p;
    logic             spx_f, spy_f, x_f, y_f;

    logic [3:0]       spx_n, spy_n;
    logic [CORDW:0]   wr_x_ext, wr_y_ext;
    logic [CORDW-1:0] wr_x_cl, wr_y_cl;
    logic [CORDW-1:0] x_mv, y_mv;
    logic             dx_mv, dy_mv, hit_x, hit_y, hit;

    // State register.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: transitions only happen on the frame pulse.
    always_comb begin
        state_nx = state;
        if (frame) state_nx = run ? MOVE : IDLE;
    end

    // FSM outputs.
    always_comb begin
        moving = (state == MOVE);
    end

    // Scale write data to pixel positions and clamp so the sprite stays fully on screen.
    always_comb begin
        wr_x_ext = {{(CORDW-9){1'b0}}, wr_data, 2'b00};
        wr_y_ext = {{(CORDW-8){1'b0}}, wr_data, 1'b0};
        wr_x_cl  = (wr_x_ext > X_MAX) ? X_MAX[CORDW-1:0] : wr_x_ext[CORDW-1:0];
        wr_y_cl  = (wr_y_ext > Y_MAX) ? Y_MAX[CORDW-1:0] : wr_y_ext[CORDW-1:0];
    end

    // One frame step on each axis using the speed that takes effect at this frame.
    always_comb begin
        spx_n = spx_f ? spx_p : spx;
        spy_n = spy_f ? spy_p : spy;
        x_mv  = x_q;  dx_mv = dx;  hit_x = 1'b0;
        y_mv  = y_q;  dy_mv = dy;  hit_y = 1'b0;
        if (!dx) begin
            if ({1'b0, x_q} + {{(CORDW-3){1'b0}}, spx_n} >= X_MAX) begin
                x_mv = X_MAX[CORDW-1:0]; dx_mv = 1'b1; hit_x = 1'b1;
            end else begin
                x_mv = x_q + {{(CORDW-4){1'b0}}, spx_n};
            end
        end else begin
            if (x_q <= {{(CORDW-4){1'b0}}, spx_n}) begin
                x_mv = '0; dx_mv = 1'b0; hit_x = 1'b1;
            end else begin
                x_mv = x_q - {{(CORDW-4){1'b0}}, spx_n};
            end
        end
        if (!dy) begin
            if ({1'b0, y_q} + {{(CORDW-3){1'b0}}, spy_n} >= Y_MAX) begin
                y_mv = Y_MAX[CORDW-1:0]; dy_mv = 1'b1; hit_y = 1'b1;
            end else begin
                y_mv = y_q + {{(CORDW-4){1'b0}}, spy_n};
            end
        end else begin
            if (y_q <= {{(CORDW-4){1'b0}}, spy_n}) begin
                y_mv = '0; dy_mv = 1'b0; hit_y = 1'b1;
            end else begin
                y_mv = y_q - {{(CORDW-4){1'b0}}, spy_n};
            end
        end
        // An axis overridden by a pending position write cannot bounce this frame.
        hit = (state == MOVE) && ((hit_x && !x_f) || (hit_y && !y_f));
    end

    // Pending write buffer; a write landing on the frame pulse survives the flag clear.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            spx_p <= '0; spy_p <= '0; x_p <= '0; y_p <= '0;
            spx_f <= 1'b0; spy_f <= 1'b0; x_f <= 1'b0; y_f <= 1'b0;
        end else begin
            if (frame) begin
                spx_f <= 1'b0; spy_f <= 1'b0; x_f <= 1'b0; y_f <= 1'b0;
            end
            if (wr_en) begin
                case (wr_sel)
                    2'd0: begin spx_p <= wr_data[3:0]; spx_f <= 1'b1; end
                    2'd1: begin spy_p <= wr_data[3:0]; spy_f <= 1'b1; end
                    2'd2: begin x_p   <= wr_x_cl;      x_f   <= 1'b1; end
                    default: begin y_p <= wr_y_cl;     y_f   <= 1'b1; end
                endcase
            end
        end
    end

    // Frame update: speeds, positions, directions and bounce bookkeeping.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= CORDW'(INIT_X); y_q <= CORDW'(INIT_Y);
            dx <= 1'b0; dy <= 1'b0;
            spx <= 4'd1; spy <= 4'd1;
            bounce <= 1'b0; bounce_cnt <= '0;
        end else begin
            bounce <= 1'b0;
            if (frame) begin
                spx <= spx_n;
                spy <= spy_n;
                if (x_f) x_q <= x_p;
                else if (state == MOVE) begin x_q <= x_mv; dx <= dx_mv; end
                if (y_f) y_q <= y_p;
                else if (state == MOVE) begin y_q <= y_mv; dy <= dy_mv; end
                bounce <= hit;
                if (hit && bounce_cnt != 8'hFF) bounce_cnt <= bounce_cnt + 8'd1;
            end
        end
    end

    assign sprx      = x_q;
    assign spry      = y_q;
    assign spr_start = line && (sy == spry);

endmodule

// File: tb/tb_sprite_mover.sv
`timescale 1ns/1ps
module tb_sprite_mover;
    logic               clk_pix = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame = 1'b0, line = 1'b0, run = 1'b0, wr_en = 1'b0;
    logic signed [15:0] sy = '0;
    logic [1:0]         wr_sel = '0;
    logic [7:0]         wr_data = '0;
    logic signed [15:0] sprx, spry;
    logic               spr_start, bounce, moving;
    logic [7:0]         bounce_cnt;

    typedef struct {
        int x; int y; logic b; int cnt; logic mv;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    logic frame_d;

    sprite_mover dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .line(line), .sy(sy),
        .run(run), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .sprx(sprx), .spry(spry), .spr_start(spr_start), .bounce(bounce),
        .bounce_cnt(bounce_cnt), .moving(moving)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response of a frame pulse is visible in the cycle after it.
    always @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) frame_d <= 1'b0;
        else        frame_d <= frame;
    end

    // Monitor: pop the expected response for every frame the DUT processes.
    always @(negedge clk_pix) begin
        if (frame_d) begin
            if (q.size() == 0) begin
                chk("unexpected_frame_response", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_sprx", int'(sprx), e.x);
                chk("frame_spry", int'(spry), e.y);
                chk("frame_bounce", int'(bounce), int'(e.b));
                chk("frame_bounce_cnt", int'(bounce_cnt), e.cnt);
                chk("frame_moving", int'(moving), int'(e.mv));
            end
        end
    end

    task automatic tick;
        @(posedge clk_pix); #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push(input int x, input int y, input logic b, input int cnt, input logic mv);
        exp_t e;
        e.x = x; e.y = y; e.b = b; e.cnt = cnt; e.mv = mv;
        q.push_back(e);
    endtask

    task automatic do_frame(input int x, input int y, input logic b, input int cnt, input logic mv);
        push(x, y, b, cnt, mv);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_wr(input logic [1:0] sel, input logic [7:0] d,
                            input int x, input int y, input logic b, input int cnt, input logic mv);
        push(x, y, b, cnt, mv);
        frame = 1'b1; wr_en = 1'b1; wr_sel = sel; wr_data = d;
        tick();
        frame = 1'b0; wr_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        tick(); tick();
        chk("rst_sprx", int'(sprx), 16);
        chk("rst_spry", int'(spry), 16);
        chk("rst_bounce_cnt", int'(bounce_cnt), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_bounce", int'(bounce), 0);
        rst_n = 1'b1;
        tick();

        // spr_start only on line pulse at sy == spry
        line = 1'b1; sy = 16'sd15; #1;
        chk("spr_start_sy15", int'(spr_start), 0);
        sy = 16'sd16; #1;
        chk("spr_start_sy16", int'(spr_start), 1);
        line = 1'b0; #1;
        chk("spr_start_noline", int'(spr_start), 0);
        tick();

        // Motion: first frame only enters MOVE
        run = 1'b1;
        do_frame(16, 16, 0, 0, 1);
        do_frame(17, 17, 0, 0, 1);
        do_frame(18, 18, 0, 0, 1);
        do_frame(19, 19, 0, 0, 1);

        // Right-edge bounce: 0x9F*4=636 clamps to 608
        wr(2'd0, 8'd4);
        wr(2'd2, 8'h9F);
        do_frame(608, 20, 0, 0, 1);
        do_frame(608, 21, 1, 1, 1);
        do_frame(604, 22, 0, 1, 1);

        // Set up corner: x=8 moving left, y=446 moving down
        wr(2'd2, 8'd2);
        wr(2'd3, 8'hDF);
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd0);
        do_frame(8, 446, 0, 1, 1);
        do_frame(5, 446, 0, 1, 1);
        do_frame(2, 446, 0, 1, 1);
        wr(2'd0, 8'd4);
        wr(2'd1, 8'd4);
        do_frame(0, 448, 1, 2, 1);

        // Write coincident with frame applies one frame later
        frame_wr(2'd3, 8'h20, 4, 444, 0, 2, 1);
        do_frame(8, 64, 0, 2, 1);

        // Freeze: last MOVE frame still moves, then position holds
        run = 1'b0;
        do_frame(12, 60, 0, 2, 0);
        do_frame(12, 60, 0, 2, 0);
        do_frame(12, 60, 0, 2, 0);
        do_frame(12, 60, 0, 2, 0);
        // Pending writes still apply in IDLE
        wr(2'd2, 8'h10);
        do_frame(64, 60, 0, 2, 0);

        // Saturation: zero speed, alternate position overrides to bounce off each edge
        wr(2'd0, 8'd0);
        wr(2'd1, 8'd0);
        run = 1'b1;
        do_frame(64, 60, 0, 2, 1);
        c = 2;
        for (int k = 0; k < 130; k++) begin
            wr(2'd2, 8'h9F);
            do_frame(608, 60, 0, c, 1);
            c = (c < 255) ? c + 1 : 255;
            do_frame(608, 60, 1, c, 1);
            wr(2'd2, 8'h00);
            do_frame(0, 60, 0, c, 1);
            c = (c < 255) ? c + 1 : 255;
            do_frame(0, 60, 1, c, 1);
        end

        // Mid-line reset with a pending write outstanding
        wr(2'd2, 8'h40);
        line = 1'b1; sy = 16'sd16;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sprx", int'(sprx), 16);
        chk("midrst_spry", int'(spry), 16);
        chk("midrst_bounce_cnt", int'(bounce_cnt), 0);
        chk("midrst_moving", int'(moving), 0);
        chk("midrst_spr_start", int'(spr_start), 1);
        tick();
        rst_n = 1'b1;
        line = 1'b0;
        run = 1'b0;
        tick();
        do_frame(16, 16, 0, 0, 0);

        tick();
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
